// File: rtl/tile_seq_ctrl.sv
// tile_seq_ctrl: parametrised tile sequencer for the FrodoKEM systolic matrix-multiply datapath.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start_i, mode_i     one-cycle start request (accepted in IDLE); mode 0 = AS, 1 = SA
//   a_ready_i           hash buffer holds the next A tile (sampled only in WAIT)
//   a_rdata_i/s_rdata_i A/S read data, one cycle after the address
//   acc_data_i          systolic output row for the current save beat
//   busy_o, done_o      busy from accepted start until done; done is a one-cycle pulse
//   a_addr_o/s_addr_o   A/S read addresses
//   left/right_data_o   array left/top inputs
//   sa_en/load/clear_o  array advance, weight-load mode, accumulator clear
//   wr_en/addr/data_o   result write-back port
//   perf_stall_o        WAIT stall counter, built only with TILE_SEQ_CTRL_PERF_EN defined
module tile_seq_ctrl #(
  parameter int TILE     = 4,
  parameter int DEPTH    = 1344,
  parameter int NBLK     = 2,
  parameter int AW       = 32,
  parameter int DW       = 64,
  parameter int A_STRIDE = 21504,
  parameter int S_STRIDE = 10752,
  parameter int B_BASE   = 86016
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start_i,
  input  logic          mode_i,
  input  logic          a_ready_i,
  input  logic [DW-1:0] a_rdata_i,
  input  logic [DW-1:0] s_rdata_i,
  input  logic [DW-1:0] acc_data_i,
  output logic          busy_o,
  output logic          done_o,
  output logic [AW-1:0] a_addr_o,
  output logic [AW-1:0] s_addr_o,
  output logic [DW-1:0] left_data_o,
  output logic [DW-1:0] right_data_o,
  output logic          sa_en_o,
  output logic          sa_load_o,
  output logic          sa_clear_o,
  output logic          wr_en_o,
  output logic [AW-1:0] wr_addr_o,
  output logic [DW-1:0] wr_data_o,
  output logic [31:0]   perf_stall_o
);
  localparam int LG   = $clog2(TILE);
  localparam int MAXB = DEPTH > 2*TILE ? DEPTH : 2*TILE;
  localparam int BW   = $clog2(MAXB);
  localparam int TW   = NBLK > 1 ? $clog2(NBLK) : 1;
  typedef enum logic [2:0] {IDLE, WAIT, LOAD, STREAM, DRAIN, SAVE} state_t;
  state_t        state_q, state_d;
  logic [BW-1:0] beat_q, beat_d;
  logic [TW-1:0] tile_q, tile_d;
  logic          mode_q, mode_d, done_q, done_d, ld_q, st_q, last;
  logic [AW-1:0] beat_w, line_w, lane_w, tile_w;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      beat_q  <= '0;
      tile_q  <= '0;
      mode_q  <= 1'b0;
      done_q  <= 1'b0;
      ld_q    <= 1'b0;
      st_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      tile_q  <= tile_d;
      mode_q  <= mode_d;
      done_q  <= done_d;
      // read data returns one cycle after the address, so remember which phase issued it
      ld_q    <= state_q == LOAD;
      st_q    <= state_q == STREAM;
    end
  always_comb begin
    last    = (state_q == LOAD || state_q == SAVE) ? beat_q == BW'(TILE-1) :
              state_q == STREAM ? beat_q == BW'(DEPTH-1) : beat_q == BW'(2*TILE-1);
    state_d = state_q;
    beat_d  = beat_q + 1'b1;
    tile_d  = tile_q;
    mode_d  = mode_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        beat_d = '0;
        if (start_i) begin
          state_d = WAIT;
          tile_d  = '0;
          mode_d  = mode_i;
        end
      end
      WAIT: begin
        beat_d = '0;
        if (a_ready_i) state_d = mode_q ? LOAD : STREAM;
      end
      LOAD:   if (last) begin state_d = STREAM; beat_d = '0; end
      STREAM: if (last) begin state_d = DRAIN;  beat_d = '0; end
      DRAIN:  if (last) begin state_d = SAVE;   beat_d = '0; end
      SAVE: if (last) begin
        beat_d = '0;
        if (tile_q == TW'(NBLK-1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = WAIT;
          tile_d  = tile_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  assign beat_w = AW'(beat_q);
  assign line_w = AW'(beat_q >> LG);
  assign lane_w = AW'(beat_q[LG-1:0]);
  assign tile_w = AW'(tile_q);
  assign a_addr_o = state_q == STREAM ? (line_w << 3) + lane_w * AW'(A_STRIDE) : '0;
  assign s_addr_o = state_q == LOAD ? tile_w * AW'(TILE*8) + beat_w * AW'(S_STRIDE) :
                    (state_q == STREAM && !mode_q) ? (line_w << 3) + lane_w * AW'(S_STRIDE) : '0;
  assign wr_addr_o = state_q == SAVE ?
                     AW'(B_BASE) + tile_w * AW'(TILE*TILE*8) + beat_w * AW'(TILE*8) : '0;
  assign wr_en_o      = state_q == SAVE;
  assign wr_data_o    = state_q == SAVE ? acc_data_i : '0;
  assign sa_en_o      = state_q == LOAD || state_q == STREAM || state_q == DRAIN;
  assign sa_load_o    = state_q == LOAD;
  assign sa_clear_o   = state_q == WAIT && a_ready_i;
  assign busy_o       = state_q != IDLE;
  assign done_o       = done_q;
  assign left_data_o  = st_q ? a_rdata_i : '0;
  // SA streams A on the left only; S was already loaded as weights
  assign right_data_o = (ld_q || (st_q && !mode_q)) ? s_rdata_i : '0;
`ifdef TILE_SEQ_CTRL_PERF_EN
  logic [31:0] perf_q, perf_d;
  always_comb
    perf_d = (state_q == IDLE && start_i) ? '0 :
             (state_q == WAIT && !a_ready_i && perf_q != '1) ? perf_q + 1'b1 : perf_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) perf_q <= '0;
    else perf_q <= perf_d;
  assign perf_stall_o = perf_q;
`else
  assign perf_stall_o = '0;
`endif
endmodule

// File: tb/tb_tile_seq_ctrl.sv
// tb_tile_seq_ctrl: self-checking bench for tile_seq_ctrl (timeline vectors plus write scoreboard).
module tb_tile_seq_ctrl;
  localparam int T = 4, D = 8, N = 2, AW = 32, DW = 64;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  logic start_i = 1'b0, mode_i = 1'b0, a_ready_i = 1'b1;
  logic [DW-1:0] a_rdata_i = '0, s_rdata_i = '0, acc_data_i = '0;
  logic busy_o, done_o, sa_en_o, sa_load_o, sa_clear_o, wr_en_o;
  logic [AW-1:0] a_addr_o, s_addr_o, wr_addr_o;
  logic [DW-1:0] left_data_o, right_data_o, wr_data_o;
  logic [31:0] perf_stall_o;
  logic start1 = 1'b0;
  logic busy1, done1, sa_en1, sa_load1, sa_clear1, wr_en1;
  logic [AW-1:0] a_addr1, s_addr1, wr_addr1;
  logic [DW-1:0] left1, right1, wr_data1;
  logic [31:0] perf1;
  tile_seq_ctrl #(.TILE(T), .DEPTH(D), .NBLK(N)) u0 (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .mode_i(mode_i), .a_ready_i(a_ready_i),
    .a_rdata_i(a_rdata_i), .s_rdata_i(s_rdata_i), .acc_data_i(acc_data_i),
    .busy_o(busy_o), .done_o(done_o), .a_addr_o(a_addr_o), .s_addr_o(s_addr_o),
    .left_data_o(left_data_o), .right_data_o(right_data_o), .sa_en_o(sa_en_o),
    .sa_load_o(sa_load_o), .sa_clear_o(sa_clear_o), .wr_en_o(wr_en_o), .wr_addr_o(wr_addr_o),
    .wr_data_o(wr_data_o), .perf_stall_o(perf_stall_o));
  tile_seq_ctrl #(.TILE(2), .DEPTH(2), .NBLK(1)) u1 (
    .clk(clk), .rst_n(rst_n), .start_i(start1), .mode_i(1'b0), .a_ready_i(1'b1),
    .a_rdata_i('0), .s_rdata_i('0), .acc_data_i('0),
    .busy_o(busy1), .done_o(done1), .a_addr_o(a_addr1), .s_addr_o(s_addr1),
    .left_data_o(left1), .right_data_o(right1), .sa_en_o(sa_en1),
    .sa_load_o(sa_load1), .sa_clear_o(sa_clear1), .wr_en_o(wr_en1), .wr_addr_o(wr_addr1),
    .wr_data_o(wr_data1), .perf_stall_o(perf1));
  typedef struct { logic [31:0] addr; logic [63:0] data; } wr_t;
  typedef struct { bit m; int r; logic [31:0] a; logic [31:0] s; bit ld; bit en; bit clr; bit wr; logic [31:0] wa; } vec_t;
  wr_t  sbq[$];
  vec_t tv[$];
  int errors = 0, checks = 0, cyc = 0, c0 = 0, lm = 0;
  bit log_on = 1'b0;
  logic [31:0] la[2][64], ls[2][64], lwa[2][64];
  logic [63:0] ll[2][64], lr[2][64];
  logic lld[2][64], len[2][64], lclr[2][64], lwr[2][64];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic add(input bit m, input int r, input logic [31:0] a, input logic [31:0] s,
                     input bit ld, input bit en, input bit clr, input bit wr, input logic [31:0] wa);
    vec_t v;
    v.m = m; v.r = r; v.a = a; v.s = s; v.ld = ld; v.en = en; v.clr = clr; v.wr = wr; v.wa = wa;
    tv.push_back(v);
  endtask

  // one clock: synchronous-read memory model, acc data tagged with the cycle, write scoreboard, logging
  task automatic step();
    logic [31:0] pa, ps;
    wr_t e;
    int r;
    pa = a_addr_o;
    ps = s_addr_o;
    @(posedge clk);
    a_rdata_i = {32'hA5A50000, pa};
    s_rdata_i = {32'h5A5A0000, ps};
    cyc++;
    acc_data_i = {32'hACC00000, 32'(cyc)};
    #2;
    if (wr_en_o) begin
      if (sbq.size() == 0) chk("wr_unexpected", wr_en_o, 0);
      else begin
        e = sbq.pop_front();
        chk("wr_addr", wr_addr_o, e.addr);
        chk("wr_data", wr_data_o, e.data);
      end
    end
    r = cyc - c0;
    if (log_on && r >= 0 && r < 64) begin
      la[lm][r] = a_addr_o; ls[lm][r] = s_addr_o; lwa[lm][r] = wr_addr_o;
      ll[lm][r] = left_data_o; lr[lm][r] = right_data_o;
      lld[lm][r] = sa_load_o; len[lm][r] = sa_en_o; lclr[lm][r] = sa_clear_o; lwr[lm][r] = wr_en_o;
    end
  endtask

  task automatic push_sb(input bit m, input int base);
    int p;
    wr_t e;
    p = 1 + D + 3*T + (m ? T : 0);
    for (int t = 0; t < N; t++)
      for (int k = 0; k < T; k++) begin
        e.addr = 32'(86016 + t*T*T*8 + k*T*8);
        e.data = {32'hACC00000, 32'(base + t*p + p - T + k)};
        sbq.push_back(e);
      end
  endtask

  task automatic launch(input bit m, input bit lg);
    mode_i = m;
    start_i = 1'b1;
    c0 = cyc + 1;
    log_on = lg;
    step();
    start_i = 1'b0;
    mode_i = ~m;
  endtask

  task automatic wait_done(output int rel);
    int n;
    n = 0;
    while (!done_o && n < 300) begin step(); n++; end
    rel = done_o ? cyc - c0 : -1;
  endtask

  int rel, dn, pb;
  initial begin
    acc_data_i = 64'hDEAD_BEEF;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_busy", busy_o, 0); chk("rst_done", done_o, 0);
    chk("rst_a_addr", a_addr_o, 0); chk("rst_s_addr", s_addr_o, 0);
    chk("rst_left", left_data_o, 0); chk("rst_right", right_data_o, 0);
    chk("rst_sa_en", sa_en_o, 0); chk("rst_sa_load", sa_load_o, 0); chk("rst_sa_clear", sa_clear_o, 0);
    chk("rst_wr_en", wr_en_o, 0); chk("rst_wr_addr", wr_addr_o, 0); chk("rst_wr_data", wr_data_o, 0);
    chk("rst_perf", perf_stall_o, 0);
    rst_n = 1'b1;
    step();
    // AS run then SA run, both logged for the vector table
    for (int m = 0; m < 2; m++) begin
      lm = m;
      launch(m[0], 1'b1);
      push_sb(m[0], c0);
      wait_done(rel);
      chk($sformatf("m%0d_done_cycle", m), rel, N * (1 + D + 3*T + (m ? T : 0)));
      chk($sformatf("m%0d_busy_at_done", m), busy_o, 0);
      step();
      chk($sformatf("m%0d_done_pulse", m), done_o, 0);
      log_on = 1'b0;
      chk($sformatf("m%0d_sb_empty", m), sbq.size(), 0);
    end
    add(0,  0, 0,     0,     0, 0, 1, 0, 0);
    add(0,  1, 0,     0,     0, 1, 0, 0, 0);
    add(0,  2, 21504, 10752, 0, 1, 0, 0, 0);
    add(0,  3, 43008, 21504, 0, 1, 0, 0, 0);
    add(0,  4, 64512, 32256, 0, 1, 0, 0, 0);
    add(0,  5, 8,     8,     0, 1, 0, 0, 0);
    add(0,  6, 21512, 10760, 0, 1, 0, 0, 0);
    add(0,  8, 64520, 32264, 0, 1, 0, 0, 0);
    add(0,  9, 0,     0,     0, 1, 0, 0, 0);
    add(0, 16, 0,     0,     0, 1, 0, 0, 0);
    add(0, 17, 0,     0,     0, 0, 0, 1, 86016);
    add(0, 18, 0,     0,     0, 0, 0, 1, 86048);
    add(0, 20, 0,     0,     0, 0, 0, 1, 86112);
    add(0, 21, 0,     0,     0, 0, 1, 0, 0);
    add(0, 22, 0,     0,     0, 1, 0, 0, 0);
    add(0, 23, 21504, 10752, 0, 1, 0, 0, 0);
    add(0, 38, 0,     0,     0, 0, 0, 1, 86144);
    add(0, 41, 0,     0,     0, 0, 0, 1, 86240);
    add(1,  0, 0,     0,     0, 0, 1, 0, 0);
    add(1,  1, 0,     0,     1, 1, 0, 0, 0);
    add(1,  2, 0,     10752, 1, 1, 0, 0, 0);
    add(1,  3, 0,     21504, 1, 1, 0, 0, 0);
    add(1,  4, 0,     32256, 1, 1, 0, 0, 0);
    add(1,  5, 0,     0,     0, 1, 0, 0, 0);
    add(1,  6, 21504, 0,     0, 1, 0, 0, 0);
    add(1,  9, 8,     0,     0, 1, 0, 0, 0);
    add(1, 13, 0,     0,     0, 1, 0, 0, 0);
    add(1, 21, 0,     0,     0, 0, 0, 1, 86016);
    add(1, 25, 0,     0,     0, 0, 1, 0, 0);
    add(1, 26, 0,     32,    1, 1, 0, 0, 0);
    add(1, 27, 0,     10784, 1, 1, 0, 0, 0);
    add(1, 46, 0,     0,     0, 0, 0, 1, 86144);
    for (int i = 0; i < tv.size(); i++) begin
      chk($sformatf("vec%0d_a_addr", i),   la[tv[i].m][tv[i].r],   tv[i].a);
      chk($sformatf("vec%0d_s_addr", i),   ls[tv[i].m][tv[i].r],   tv[i].s);
      chk($sformatf("vec%0d_sa_load", i),  lld[tv[i].m][tv[i].r],  tv[i].ld);
      chk($sformatf("vec%0d_sa_en", i),    len[tv[i].m][tv[i].r],  tv[i].en);
      chk($sformatf("vec%0d_sa_clear", i), lclr[tv[i].m][tv[i].r], tv[i].clr);
      chk($sformatf("vec%0d_wr_en", i),    lwr[tv[i].m][tv[i].r],  tv[i].wr);
      chk($sformatf("vec%0d_wr_addr", i),  lwa[tv[i].m][tv[i].r],  tv[i].wa);
    end
    // array data lags its address by exactly one cycle
    for (int m = 0; m < 2; m++) begin
      int l;
      l = m ? T : 0;
      for (int b = 0; b < D; b++) begin
        chk($sformatf("m%0d_left_b%0d", m, b), ll[m][2+l+b], {32'hA5A50000, 32'((b/T)*8 + (b%T)*21504)});
        chk($sformatf("m%0d_right_b%0d", m, b), lr[m][2+l+b],
            m ? 64'd0 : {32'hA5A50000 ^ 32'hFFFF0000 ^ 32'h00000000, 32'((b/T)*8 + (b%T)*10752)} ^ 64'h0);
      end
      chk($sformatf("m%0d_drain_left", m), ll[m][3+l+D], 0);
      chk($sformatf("m%0d_drain_right", m), lr[m][3+l+D], 0);
    end
    for (int b = 0; b < T; b++) begin
      chk($sformatf("load_right_b%0d", b), lr[1][2+b], {32'h5A5A0000, 32'(b*10752)});
      chk($sformatf("load_left_b%0d", b), ll[1][2+b], 0);
    end
    // a_ready held low in WAIT
    a_ready_i = 1'b0;
    launch(1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("stall_busy", busy_o, 1); chk("stall_a_addr", a_addr_o, 0); chk("stall_s_addr", s_addr_o, 0);
      chk("stall_sa_en", sa_en_o, 0); chk("stall_sa_clear", sa_clear_o, 0);
    end
`ifdef TILE_SEQ_CTRL_PERF_EN
    chk("perf_stall", perf_stall_o, 10);
`else
    chk("perf_stall", perf_stall_o, 0);
`endif
    a_ready_i = 1'b1;
    #1;
    chk("stall_exit_clear", sa_clear_o, 1);
    c0 = cyc;
    push_sb(1'b0, c0);
    wait_done(rel);
    chk("stall_done_cycle", rel, 42);
    chk("stall_sb_empty", sbq.size(), 0);
    // start and mode pulsed during STREAM, a_ready dropped outside WAIT
    launch(1'b0, 1'b0);
    push_sb(1'b0, c0);
    while (cyc - c0 < 3) step();
    start_i = 1'b1; mode_i = 1'b1; a_ready_i = 1'b0;
    step();
    start_i = 1'b0;
    while (cyc - c0 < 15) step();
    a_ready_i = 1'b1;
    wait_done(rel);
    chk("restart_done_cycle", rel, 42);
    dn = 0;
    for (int i = 0; i < 30; i++) begin step(); dn += int'(done_o); end
    chk("restart_extra_done", dn, 0);
    chk("restart_busy_after", busy_o, 0);
    chk("restart_sb_empty", sbq.size(), 0);
    // reset during SAVE beat 2
    launch(1'b0, 1'b0);
    push_sb(1'b0, c0);
    while (cyc - c0 < 19) step();
    chk("pre_rst_wr_en", wr_en_o, 1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_wr_en", wr_en_o, 0); chk("rst_mid_busy", busy_o, 0);
    chk("rst_mid_sa_en", sa_en_o, 0); chk("rst_mid_wr_addr", wr_addr_o, 0);
    sbq.delete();
    step();
    rst_n = 1'b1;
    step();
    chk("post_rst_idle", busy_o, 0);
    launch(1'b0, 1'b0);
    push_sb(1'b0, c0);
    wait_done(rel);
    chk("post_rst_done_cycle", rel, 42);
    chk("post_rst_sb_empty", sbq.size(), 0);
    // NBLK=1, TILE=2, DEPTH=2 instance
    start1 = 1'b1;
    step();
    start1 = 1'b0;
    c0 = cyc;
    pb = 0;
    rel = 0;
    while (!done1 && rel < 100) begin pb = int'(busy1); step(); rel++; end
    chk("n1_done_cycle", cyc - c0, 9);
    chk("n1_busy_at_done", busy1, 0);
    chk("n1_busy_before_done", pb, 1);
    step();
    chk("n1_done_pulse", done1, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/tile_seq_ctrl.md
# tile_seq_ctrl

Parametrised tile-sequencing controller for the FrodoKEM systolic matrix-multiply datapath. Generalises the fixed 4x4 AS/SA memory controller to any power-of-two tile edge, inner depth and output-tile count. Adds:
- a start/busy/done handshake;
- per-tile back-pressure from the hash (A) producer;
- an explicit drain phase;
- a result write-back phase.

It sits between the SHAKE/hash buffer, the single-port S/B RAM and the systolic array.

## Interface
- TILE, 4, systolic array edge and lanes per tile; power of two, at least 2
- DEPTH, 1344, beats streamed per tile; multiple of TILE
- NBLK, 2, output tiles per start, at least 1
- AW, 32, address width
- DW, 64, data width
- A_STRIDE, 21504, address step between A lanes (1344*16)
- S_STRIDE, 10752, address step between S lanes (1344*8)
- B_BASE, 86016, base address of the result region (1344*64)
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- start  in  1  one-cycle request; sampled only in IDLE
- mode  in  1  0 = AS (A·S), 1 = SA (S·A); latched on accepted start
- a_ready  in  1  hash buffer holds the next A tile
- a_rdata  in  DW  A read data, 1-cycle latency
- s_rdata  in  DW  S read data, 1-cycle latency
- acc_data  in  DW  systolic output row for the current save beat
- busy  out  1  high from the accepted start until done
- done  out  1  one-cycle pulse after the last tile is saved
- a_addr  out  AW  A read address
- s_addr  out  AW  S read address
- left_data  out  DW  array left input
- right_data  out  DW  array top input
- sa_en  out  1  array advance enable
- sa_load  out  1  array in weight-load mode
- sa_clear  out  1  one-cycle accumulator clear at the start of each tile
- wr_en  out  1  result write strobe
- wr_addr  out  AW  result write address
- wr_data  out  DW  result write data
- perf_stall  out  32  WAIT-cycle counter (see Configuration)

## Operation
- States and transitions:
  - IDLE: start goes to WAIT.
  - WAIT: a_ready goes to LOAD if mode=1, otherwise to STREAM.
  - LOAD: after TILE cycles, goes to STREAM.
  - STREAM: after DEPTH cycles, goes to DRAIN.
  - DRAIN: after 2*TILE cycles, goes to SAVE.
  - SAVE: after TILE cycles, goes to WAIT, or to IDLE with done when tile_idx==NBLK-1.
- Counters:
  - beat counts within each state.
  - lane = beat mod TILE; line = beat / TILE.
  - tile_idx counts 0..NBLK-1 and is cleared on an accepted start.
- LOAD (SA only):
  - s_addr = tile_idx*TILE*8 + beat*S_STRIDE.
  - sa_load=1.
  - right_data = s_rdata one cycle later; left_data=0.
- STREAM:
  - a_addr = line*8 + lane*A_STRIDE.
  - In AS mode, s_addr = line*8 + lane*S_STRIDE.
  - left_data = a_rdata and right_data = s_rdata, registered one cycle after the address. In SA mode, right_data=0.
- DRAIN: sa_en=1, both data buses 0.
- SAVE:
  - wr_en=1.
  - wr_addr = B_BASE + tile_idx*TILE*TILE*8 + beat*TILE*8.
  - wr_data = acc_data.
- sa_clear pulses in the cycle WAIT exits.
- sa_en is high during LOAD, STREAM (including its final read-latency cycle) and DRAIN, and low elsewhere.
- Address arithmetic is in AW bits and wraps modulo 2^AW without error.
- start while busy is ignored. mode changes while busy are ignored.
- a_ready is sampled only in WAIT. Dropping it in any other state has no effect.
- NBLK=1: done follows the first SAVE.

## Timing
- Reset values: every output is 0, and the state is IDLE.
- Reset mid-operation returns the block to IDLE immediately with no write issued.
- busy rises the cycle after start is accepted and falls in the same cycle done pulses.
- Read-to-array latency is 1 cycle: left_data/right_data lag the address by exactly one clk.
- Per-tile cycles with a_ready held high:
  - AS: 1 + DEPTH + 2*TILE + TILE.
  - SA: adds TILE more.
- done asserts the cycle after the final SAVE beat.

## Configuration
- TILE_SEQ_CTRL_PERF_EN:
  - Defined: perf_stall counts every cycle spent in WAIT with a_ready=0. It clears on an accepted start and saturates at 2^32-1.
  - Undefined: perf_stall is tied to 0 and no counter logic is built.

## Test plan
- AS, TILE=4, DEPTH=8, NBLK=2, a_ready=1 -> 2 tiles of 21 cycles each. a_addr sequence 0, 21504, 43008, 64512, 8, 21512, … Writes at 86016, 86048, 86080, 86112, then 86144…
- SA, same parameters -> 4 LOAD beats, s_addr = 0, 10752, 21504, 32256, with sa_load=1. Tile 1 LOAD starts at s_addr 32. Per-tile cycle count 25.
- a_ready held low for 10 cycles in WAIT -> no addresses issued, state stays WAIT. With PERF_EN, perf_stall=10.
- start pulsed during STREAM -> ignored; exactly NBLK tiles are produced and a single done pulse is issued.
- rst_n asserted during SAVE beat 2 -> wr_en=0 the same cycle, busy=0, and a new start runs the full sequence from tile 0.
- NBLK=1, TILE=2, DEPTH=2 -> done at cycle 1+2+4+2 after WAIT entry, and busy falls with it.
